spike_address_queue: RTL

- Upstream feeder for the per-neuron MAC stage.
- Buffers spike source addresses arriving from the NoC router interface with a valid/ready handshake.
- Presents at most one address per cycle on the MAC's 12-bit source_address input, driving an idle (non-matching) address when there is nothing to send.
- Sequences end-of-timestep: drains the queue, flushes the MAC pipeline, then pulses step_done to the potential-update stage.

---
 rtl/spike_address_queue_if.sv | 15 +
 rtl/spike_address_queue.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spike_address_queue_if.sv
// Router-side spike handshake for spike_address_queue.
//   spike_valid : router presents spike_addr
//   spike_addr  : spike source address
//   spike_ready : queue accepts this cycle
// master = router (drives valid/addr), slave = queue (drives ready).
interface spike_address_queue_if #(
  parameter int ADDR_W = 12
);
  logic              spike_valid;
  logic [ADDR_W-1:0] spike_addr;
  logic              spike_ready;

  modport master (output spike_valid, output spike_addr, input spike_ready);
  modport slave  (input spike_valid, input spike_addr, output spike_ready);
endinterface

// File: rtl/spike_address_queue.sv
// spike_address_queue: buffers spike source addresses from the NoC router
// and feeds them one per cycle to the MAC stage, inserting an idle bubble
// between repeated addresses. Sequences end-of-timestep: drain the queue,
// idle FLUSH_CYCLES cycles for the MAC pipeline, then pulse step_done.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   rtr (slave)     : spike_valid / spike_addr / spike_ready handshake
//   time_step_end   : single-cycle end-of-timestep pulse
//   source_address  : registered address to MAC (IDLE_ADDR when idle)
//   addr_valid      : registered, source_address is a real spike
//   step_done       : registered one-cycle pulse, timestep fully consumed
//   fifo_count      : current occupancy
//   overflow        : sticky, push attempted while full in RUN
//
// Optional feature macro: SPIKE_DEDUP_EN -- drop a push equal to the last
// accepted address of the current timestep (still acknowledged).
module spike_address_queue #(
  parameter int                ADDR_W       = 12,
  parameter int                DEPTH        = 8,
  parameter logic [ADDR_W-1:0] IDLE_ADDR    = {ADDR_W{1'b1}},
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spike_address_queue_if.slave       rtr,
  input  logic                       time_step_end,
  output logic [ADDR_W-1:0]          source_address,
  output logic                       addr_valid,
  output logic                       step_done,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [FCW-1:0]    flush_cnt;
  logic              done_nxt;
  logic              push, wr, pop, bubble;

  assign rtr.spike_ready = (state == RUN) && (count < CW'(DEPTH));
  assign push            = rtr.spike_valid && rtr.spike_ready;
  // MAC decode is change-sensitive: a repeat of the address currently on
  // the bus must be separated by one idle cycle.
  assign bubble          = addr_valid && (mem[head] == source_address);
  assign pop             = (count != '0) && !bubble;
  assign fifo_count      = count;

`ifdef SPIKE_DEDUP_EN
  logic              last_vld;
  logic [ADDR_W-1:0] last_addr;

  assign wr = push && !(last_vld && (rtr.spike_addr == last_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld  <= 1'b0;
      last_addr <= '0;
    end else if (state == RUN && time_step_end) begin
      last_vld  <= 1'b0;  // new timestep starts fresh
    end else if (push) begin
      last_vld  <= 1'b1;
      last_addr <= rtr.spike_addr;
    end
  end
`else
  assign wr = push;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (time_step_end)   state_nxt = DRAIN;
      DRAIN:   if (count == '0)     state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == '0) state_nxt = RUN;
      default:                      state_nxt = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    done_nxt = (state == FLUSH) && (flush_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
      step_done <= 1'b0;
    end else begin
      step_done <= done_nxt;
      if (state == DRAIN && count == '0)
        flush_cnt <= FCW'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FCW'(1);
    end
  end

  // Storage has no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr) mem[tail] <= rtr.spike_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      source_address <= IDLE_ADDR;
      addr_valid     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (wr) tail <= tail + PW'(1);
      if (pop) begin
        source_address <= mem[head];
        addr_valid     <= 1'b1;
        head           <= head + PW'(1);
      end else begin
        source_address <= IDLE_ADDR;
        addr_valid     <= 1'b0;
      end
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (state == RUN && rtr.spike_valid && !rtr.spike_ready)
        overflow <= 1'b1;
    end
  end
endmodule
